// File: rtl/frame_update_sequencer.sv
// rtl/frame_update_sequencer.sv - per-frame scheduler granting one object-update slot at a time
module frame_update_sequencer #(
   parameter int ALIEN_DIV = 8,
   parameter int TIMEOUT   = 1023
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Frame_start,
   input  logic        Enable,
   input  logic [3:0]  Upd_done,
   input  logic        Err_clr,
   output logic [3:0]  Upd_start,
   output logic        Busy,
   output logic [15:0] Frame_cnt,
   output logic        Overrun,
   output logic        Timeout_err
);

   localparam int DW = (ALIEN_DIV > 1) ? $clog2(ALIEN_DIV) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(ALIEN_DIV - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_SKIP} state_t;

   state_t        state, state_nx;
   logic [1:0]    idx, idx_nx;
   logic [DW-1:0] div;
   logic          alien_en;
   logic [TW-1:0] tmo_cnt;
   logic          accept, done_sel, expired, advance, tmo_hit, ovr_hit;

   // Next state: done is honoured from the edge ending START, so a done coincident
   // with the strobe retires the slot with no idle gap
   always_comb begin
      done_sel = Upd_done[idx];
      accept   = (state == S_IDLE) && Frame_start && Enable;
      expired  = (state == S_WAIT) && (tmo_cnt == TO_LAST);
      advance  = ((state == S_START) || (state == S_WAIT)) && (done_sel || expired);
      tmo_hit  = advance && !done_sel;
      ovr_hit  = Frame_start && (state != S_IDLE);
      state_nx = state;
      idx_nx   = idx;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nx = S_START;
               idx_nx   = 2'd0;
            end
         end
         S_START, S_WAIT: begin
            if (advance) begin
               if (idx == 2'd3) begin
                  state_nx = S_IDLE;
                  idx_nx   = 2'd0;
               end else begin
                  idx_nx   = idx + 2'd1;
                  state_nx = ((idx == 2'd1) && !alien_en) ? S_SKIP : S_START;
               end
            end else begin
               state_nx = S_WAIT;
            end
         end
         S_SKIP: begin
            idx_nx   = idx + 2'd1;
            state_nx = S_START;
         end
         default: begin
            state_nx = S_IDLE;
            idx_nx   = 2'd0;
         end
      endcase
   end

   // State, slot index and per-slot wait counter (cleared outside WAIT)
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state   <= S_IDLE;
         idx     <= 2'd0;
         tmo_cnt <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         if (state == S_WAIT) tmo_cnt <= tmo_cnt + TW'(1);
         else                 tmo_cnt <= '0;
      end
   end

   // Accepted-frame counter and alien formation divider
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         Frame_cnt <= 16'd0;
         div       <= '0;
         alien_en  <= 1'b0;
      end else if (accept) begin
         Frame_cnt <= Frame_cnt + 16'd1;
         alien_en  <= (div == '0);
         div       <= (div == DIV_LAST) ? '0 : div + DW'(1);
      end
   end

   // Sticky error flags; a new event on the clearing edge keeps the flag set
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         Overrun     <= 1'b0;
         Timeout_err <= 1'b0;
      end else begin
         if (ovr_hit)      Overrun <= 1'b1;
         else if (Err_clr) Overrun <= 1'b0;
         if (tmo_hit)      Timeout_err <= 1'b1;
         else if (Err_clr) Timeout_err <= 1'b0;
      end
   end

   // Outputs decoded from registered state: one-hot strobe only in START
   always_comb begin
      Busy      = (state != S_IDLE);
      Upd_start = 4'b0000;
      if (state == S_START) Upd_start[idx] = 1'b1;
   end

endmodule

// File: tb/tb_frame_update_sequencer.sv
// tb/tb_frame_update_sequencer.sv - bench for frame_update_sequencer
module tb_frame_update_sequencer;

   localparam int ADIV = 8;
   localparam int TMO  = 16;
   localparam int GAP  = 4;

   logic        Clk;
   logic        Reset;
   logic        Frame_start;
   logic        Enable;
   logic [3:0]  Upd_done;
   logic        Err_clr;
   logic [3:0]  Upd_start;
   logic        Busy;
   logic [15:0] Frame_cnt;
   logic        Overrun;
   logic        Timeout_err;

   int errors = 0;
   int checks = 0;

   frame_update_sequencer #(.ALIEN_DIV(ADIV), .TIMEOUT(TMO)) dut (
      .Clk(Clk), .Reset(Reset), .Frame_start(Frame_start), .Enable(Enable),
      .Upd_done(Upd_done), .Err_clr(Err_clr), .Upd_start(Upd_start), .Busy(Busy),
      .Frame_cnt(Frame_cnt), .Overrun(Overrun), .Timeout_err(Timeout_err)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Reference model: a frame is a plan of slots (GAP = skipped alien cycle);
   // m_age counts edges since the current slot's strobe.
   int          m_plan[$];
   int          m_cur = -1;
   int          m_age = 0;
   int          m_acc = 0;
   logic [15:0] m_cnt = 16'd0;
   logic        m_ovr = 1'b0;
   logic        m_terr = 1'b0;
   logic        m_oset, m_tset, m_done;

   always @(posedge Clk) begin
      if (!Reset) begin
         m_plan.delete();
         m_cur = -1; m_age = 0; m_acc = 0;
         m_cnt = 16'd0; m_ovr = 1'b0; m_terr = 1'b0;
      end else begin
         m_oset = Frame_start && (m_cur != -1);
         m_tset = 1'b0;
         if (m_cur == -1) begin
            if (Frame_start && Enable) begin
               m_cnt = m_cnt + 16'd1;
               m_plan.delete();
               m_plan.push_back(1);
               m_plan.push_back(((m_acc % ADIV) == 0) ? 2 : GAP);
               m_plan.push_back(3);
               m_acc++;
               m_cur = 0; m_age = 0;
            end
         end else if (m_cur == GAP) begin
            m_cur = m_plan.pop_front(); m_age = 0;
         end else begin
            m_age++;
            m_done = Upd_done[m_cur];
            if (m_done || m_age > TMO) begin
               if (!m_done) m_tset = 1'b1;
               m_cur = (m_plan.size() == 0) ? -1 : m_plan.pop_front();
               m_age = 0;
            end
         end
         if (m_oset) m_ovr = 1'b1; else if (Err_clr) m_ovr = 1'b0;
         if (m_tset) m_terr = 1'b1; else if (Err_clr) m_terr = 1'b0;
      end
   end

   function automatic logic [3:0] m_start();
      logic [3:0] s;
      s = 4'b0000;
      if (m_cur >= 0 && m_cur < 4 && m_age == 0) s[m_cur] = 1'b1;
      return s;
   endfunction

   function automatic logic [22:0] pk(logic [3:0] s, logic b, logic [15:0] c, logic o, logic t);
      return {s, b, c, o, t};
   endfunction

   task automatic tick();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        rst, fs, en;
      logic [3:0]  done;
      logic        clr;
      logic [3:0]  e_start;
      logic        e_busy;
      logic [15:0] e_cnt;
      logic        e_ovr, e_terr;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs[NV];

   int n, n2, stall;
   logic terr_before;
   logic [3:0] seq[8];
   logic [3:0] exp3;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // rst fs en done clr | start busy cnt ovr terr
      vecs[0]  = '{1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 4'b0000, 1'b0, 16'd0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 4'b0000, 1'b0, 16'd0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 4'b0001, 1'b1, 16'd1, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 4'b0010, 1'b1, 16'd1, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 4'b0100, 1'b1, 16'd1, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 4'b1000, 1'b1, 16'd1, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 4'b0000, 1'b0, 16'd1, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 4'b0000, 1'b0, 16'd1, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 4'b0000, 1'b0, 16'd1, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 4'b0001, 1'b1, 16'd2, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b1, 16'd2, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 4'b0010, 1'b1, 16'd2, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 4'b0000, 1'b1, 16'd2, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 4'b1000, 1'b1, 16'd2, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 4'b0000, 1'b0, 16'd2, 1'b0, 1'b0};

      Reset = 1'b0; Frame_start = 1'b0; Enable = 1'b1; Upd_done = 4'hF; Err_clr = 1'b0;

      // Reset state, basic frame, Enable gating
      for (int i = 0; i < NV; i++) begin
         Reset = vecs[i].rst; Frame_start = vecs[i].fs; Enable = vecs[i].en;
         Upd_done = vecs[i].done; Err_clr = vecs[i].clr;
         tick();
         check($sformatf("vec%0d", i), pk(Upd_start, Busy, Frame_cnt, Overrun, Timeout_err),
               pk(vecs[i].e_start, vecs[i].e_busy, vecs[i].e_cnt, vecs[i].e_ovr, vecs[i].e_terr));
      end
      Enable = 1'b1; Frame_start = 1'b0;

      // Timeout on slot 1 in an alien-enabled frame
      Reset = 1'b0; tick(); tick(); Reset = 1'b1;
      Upd_done = 4'b1101; Frame_start = 1'b1; tick(); Frame_start = 1'b0;
      check("t3_s0", Upd_start, 4'b0001);
      tick();
      check("t3_s1", Upd_start, 4'b0010);
      n = 0;
      do begin
         terr_before = Timeout_err;
         tick();
         n++;
      end while (Upd_start == 4'b0000 && n < 40);
      check("t3_latency", n, 17);
      check("t3_s2", Upd_start, 4'b0100);
      check("t3_terr_set", Timeout_err, 1'b1);
      check("t3_terr_before", terr_before, 1'b0);
      Upd_done = 4'hF; tick(); tick();
      check("t3_sticky", {Busy, Timeout_err}, 2'b01);
      Err_clr = 1'b1; tick(); Err_clr = 1'b0;
      check("t3_clr", Timeout_err, 1'b0);

      // Done arriving exactly on the expiry edge: no error; skipped alien slot gap
      Upd_done = 4'b1101; Frame_start = 1'b1; tick(); Frame_start = 1'b0;
      check("t3b_s0", Upd_start, 4'b0001);
      tick();
      check("t3b_s1", Upd_start, 4'b0010);
      repeat (16) tick();
      Upd_done = 4'hF; tick();
      check("t3b_gap", pk(Upd_start, Busy, Frame_cnt, Overrun, Timeout_err),
            pk(4'b0000, 1'b1, 16'd2, 1'b0, 1'b0));
      tick();
      check("t3b_s3", Upd_start, 4'b1000);
      tick();
      check("t3b_idle", Busy, 1'b0);

      // Overrun during WAIT and on the slot-3 retire edge (set beats Err_clr)
      Upd_done = 4'h0; Frame_start = 1'b1; tick(); Frame_start = 1'b0;
      check("t4_s0", {Upd_start, Frame_cnt}, {4'b0001, 16'd3});
      tick();
      Frame_start = 1'b1; tick(); Frame_start = 1'b0;
      check("t4_wait_ovr", pk(Upd_start, Busy, Frame_cnt, Overrun, Timeout_err),
            pk(4'b0000, 1'b1, 16'd3, 1'b1, 1'b0));
      Err_clr = 1'b1; tick(); Err_clr = 1'b0;
      check("t4_clr", Overrun, 1'b0);
      Upd_done = 4'hF; tick();
      check("t4_s1", Upd_start, 4'b0010);
      tick(); tick();
      check("t4_s3", Upd_start, 4'b1000);
      Frame_start = 1'b1; Err_clr = 1'b1; tick(); Frame_start = 1'b0; Err_clr = 1'b0;
      check("t4_retire_ovr", pk(Upd_start, Busy, Frame_cnt, Overrun, Timeout_err),
            pk(4'b0000, 1'b0, 16'd3, 1'b1, 1'b0));
      tick();
      check("t4_no_second", pk(Upd_start, Busy, Frame_cnt, Overrun, Timeout_err),
            pk(4'b0000, 1'b0, 16'd3, 1'b1, 1'b0));

      // Reset during WAIT on slot 1, then restart with the alien slot enabled
      Frame_start = 1'b1; tick(); Frame_start = 1'b0;
      Upd_done = 4'b1101; tick();
      check("t5_s1", Upd_start, 4'b0010);
      tick();
      Reset = 1'b0; tick(); Reset = 1'b1;
      check("t5_reset", pk(Upd_start, Busy, Frame_cnt, Overrun, Timeout_err), 23'h0);
      Upd_done = 4'hF; Frame_start = 1'b1; tick(); Frame_start = 1'b0;
      check("t5_restart", pk(Upd_start, Busy, Frame_cnt, Overrun, Timeout_err),
            pk(4'b0001, 1'b1, 16'd1, 1'b0, 1'b0));

      // Alien divider over 9 frames (frame 1 already running)
      n2 = 0;
      for (int f = 1; f <= 9; f++) begin
         if (f > 1) begin
            Frame_start = 1'b1; tick(); Frame_start = 1'b0;
         end
         n = 0;
         while (Busy && n < 8) begin
            seq[n] = Upd_start;
            if (Upd_start[2]) n2++;
            n++;
            tick();
         end
         exp3 = (f == 1 || f == 9) ? 4'b0100 : 4'b0000;
         check($sformatf("t2_len_f%0d", f), n, 4);
         check($sformatf("t2_seq_f%0d", f), {seq[0], seq[1], seq[2], seq[3]},
               {4'b0001, 4'b0010, exp3, 4'b1000});
      end
      check("t2_pulses", n2, 2);
      check("t2_cnt", Frame_cnt, 16'd9);

      // Randomized traffic against the reference model
      stall = 0;
      for (int i = 0; i < 4000; i++) begin
         Reset       = ($urandom_range(0, 499) != 0);
         Frame_start = ($urandom_range(0, 7) == 0);
         Enable      = ($urandom_range(0, 9) != 0);
         Err_clr     = ($urandom_range(0, 29) == 0);
         if (stall > 0) begin
            Upd_done = 4'h0;
            stall--;
         end else begin
            Upd_done = 4'($urandom);
            if ($urandom_range(0, 29) == 0) stall = $urandom_range(10, 25);
         end
         tick();
         check("rand", pk(Upd_start, Busy, Frame_cnt, Overrun, Timeout_err),
               pk(m_start(), (m_cur != -1), m_cnt, m_ovr, m_terr));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
